input_pingpong_scheduler: RTL and testbench

//  Schedules the two-entry input ping-pong buffer between the DMA (DRAM->buffer fill) and buffer2sram_input (buffer->input SRAM drain).

---
 rtl/input_pingpong_scheduler.sv | 132 +++++++++++++
 tb/tb_input_pingpong_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_pingpong_scheduler.sv
// input_pingpong_scheduler: fills one input buffer from DMA while draining the other to SRAM; SCHED_PERF_EN adds stall counters
module input_pingpong_scheduler #(
   parameter int ADDR_W = 7,
   parameter int TILE_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sched_start,
   input  logic [TILE_W-1:0] num_tiles,
   input  logic [ADDR_W-1:0] tile_words,
   input  logic              drain_ready,
   output logic              dma_start,
   output logic              dma_buf_select,
   input  logic              dma_done,
   output logic              b2s_start,
   output logic              b2s_buf_select,
   output logic [ADDR_W-1:0] b2s_buf_addr_end,
   input  logic              b2s_done,
   output logic [1:0]        input_buffer_rw_select,
   output logic              sched_busy,
   output logic              sched_done,
`ifdef SCHED_PERF_EN
   output logic [15:0]       fill_stall_cnt,
   output logic [15:0]       drain_stall_cnt,
`endif
   output logic              sched_err
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} buf_t;
   state_t            state, next_state;
   buf_t              bs [2];
   logic              fill_out, drain_out, fill_ptr, drain_ptr;
   logic [TILE_W-1:0] num, issued, drained;
   logic              start_ok, fill_go, drain_go, dma_ok, b2s_ok;
   assign start_ok = state == IDLE && sched_start;
   assign fill_go  = state == RUN && !fill_out && issued < num && bs[fill_ptr] == EMPTY;
   assign drain_go = state == RUN && !drain_out && bs[drain_ptr] == FULL && drain_ready;
   assign dma_ok   = dma_done && fill_out;
   assign b2s_ok   = b2s_done && drain_out;
   // top-level run state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else state <= next_state;
   end
   // run sequencing: a zero-tile run goes straight to DONE; a run ends the cycle after the last drain lands
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (sched_start) next_state = (num_tiles == '0) ? DONE : RUN;
         RUN:     if (drained == num) next_state = DONE;
         default: next_state = IDLE;
      endcase
      sched_busy = state == RUN;
      sched_done = state == DONE;
   end
   // per-buffer state, alternating pointers, tile counters and registered engine start pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bs[0]                  <= EMPTY;
         bs[1]                  <= EMPTY;
         fill_out               <= 1'b0;
         drain_out              <= 1'b0;
         fill_ptr               <= 1'b0;
         drain_ptr              <= 1'b0;
         num                    <= '0;
         issued                 <= '0;
         drained                <= '0;
         dma_start              <= 1'b0;
         dma_buf_select         <= 1'b0;
         b2s_start              <= 1'b0;
         b2s_buf_select         <= 1'b0;
         b2s_buf_addr_end       <= '0;
         input_buffer_rw_select <= 2'b11;
         sched_err              <= 1'b0;
      end else begin
         dma_start <= fill_go;
         b2s_start <= drain_go;
         if (start_ok) begin
            num              <= num_tiles;
            b2s_buf_addr_end <= tile_words;
            issued           <= '0;
            drained          <= '0;
            fill_ptr         <= 1'b0;
            drain_ptr        <= 1'b0;
         end
         if (fill_go) begin
            dma_buf_select                   <= fill_ptr;
            bs[fill_ptr]                     <= FILL;
            input_buffer_rw_select[fill_ptr] <= 1'b1;
            fill_out                         <= 1'b1;
            issued                           <= issued + TILE_W'(1);
         end
         if (dma_ok) begin
            bs[dma_buf_select] <= FULL;
            fill_out           <= 1'b0;
            fill_ptr           <= ~fill_ptr;
         end
         if (drain_go) begin
            b2s_buf_select                    <= drain_ptr;
            bs[drain_ptr]                     <= DRAIN;
            input_buffer_rw_select[drain_ptr] <= 1'b0;
            drain_out                         <= 1'b1;
         end
         if (b2s_ok) begin
            bs[b2s_buf_select]                     <= EMPTY;
            input_buffer_rw_select[b2s_buf_select] <= 1'b1;
            drain_out                              <= 1'b0;
            drain_ptr                              <= ~drain_ptr;
            drained                                <= drained + TILE_W'(1);
         end
         if ((dma_done && !fill_out) || (b2s_done && !drain_out)) sched_err <= 1'b1;
      end
   end
`ifdef SCHED_PERF_EN
   logic fill_stall, drain_stall;
   assign fill_stall  = state == RUN && !fill_out && issued < num && bs[fill_ptr] != EMPTY;
   assign drain_stall = state == RUN && !drain_out && bs[drain_ptr] == FULL && !drain_ready;
   // saturating stall counters, cleared when a run is accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill_stall_cnt  <= '0;
         drain_stall_cnt <= '0;
      end else if (start_ok) begin
         fill_stall_cnt  <= '0;
         drain_stall_cnt <= '0;
      end else begin
         if (fill_stall && fill_stall_cnt != 16'hFFFF) fill_stall_cnt <= fill_stall_cnt + 16'd1;
         if (drain_stall && drain_stall_cnt != 16'hFFFF) drain_stall_cnt <= drain_stall_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_input_pingpong_scheduler.sv
// tb_input_pingpong_scheduler: directed and randomized checks of the ping-pong scheduler against a tile-count model
module tb_input_pingpong_scheduler;
   logic        clk = 1'b0, rst = 1'b0;
   logic        sched_start, drain_ready, dma_done, b2s_done;
   logic [15:0] num_tiles;
   logic [6:0]  tile_words;
   logic        dma_start, dma_buf_select, b2s_start, b2s_buf_select;
   logic [6:0]  b2s_buf_addr_end;
   logic [1:0]  input_buffer_rw_select;
   logic        sched_busy, sched_done, sched_err;
`ifdef SCHED_PERF_EN
   logic [15:0] fill_stall_cnt, drain_stall_cnt;
`endif
   logic f_dma = 1'b0, f_b2s = 1'b0, r_dma = 1'b0, r_b2s = 1'b0;
   assign dma_done = r_dma | f_dma;
   assign b2s_done = r_b2s | f_b2s;
   always #5 clk = ~clk;

   input_pingpong_scheduler dut (
      .clk(clk), .rst(rst), .sched_start(sched_start), .num_tiles(num_tiles), .tile_words(tile_words),
      .drain_ready(drain_ready), .dma_start(dma_start), .dma_buf_select(dma_buf_select), .dma_done(dma_done),
      .b2s_start(b2s_start), .b2s_buf_select(b2s_buf_select), .b2s_buf_addr_end(b2s_buf_addr_end),
      .b2s_done(b2s_done), .input_buffer_rw_select(input_buffer_rw_select), .sched_busy(sched_busy),
`ifdef SCHED_PERF_EN
      .fill_stall_cnt(fill_stall_cnt), .drain_stall_cnt(drain_stall_cnt),
`endif
      .sched_done(sched_done), .sched_err(sched_err)
   );

   int tests = 0, fails = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // model: run phase (0 idle, 1 run, 2 done) plus counts of fills issued/completed and drains issued/completed
   int   m_phase = 0, m_num = 0, m_tw = 0, iss = 0, fdn = 0, dis = 0, drn = 0, drn0 = 0;
   int   m_fst = 0, m_dst = 0, both_cnt = 0;
   bit   m_err = 0, p_dma_start = 0, p_dma_sel = 0, p_b2s_start = 0, p_b2s_sel = 0;
   bit   fo, dout, gf, gd, sf, sd;
   logic [1:0] erw;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase = 0; m_num = 0; m_tw = 0; iss = 0; fdn = 0; dis = 0; drn = 0; m_err = 0;
         p_dma_start = 0; p_dma_sel = 0; p_b2s_start = 0; p_b2s_sel = 0; m_fst = 0; m_dst = 0;
      end else begin
         fo = iss > fdn;
         dout = dis > drn;
         gf = m_phase == 1 && !fo && iss < m_num && iss - drn < 2;
         gd = m_phase == 1 && !dout && fdn > dis && drain_ready;
         sf = m_phase == 1 && !fo && iss < m_num && iss - drn >= 2;
         sd = m_phase == 1 && !dout && fdn > dis && !drain_ready;
         if (dma_done && b2s_done) both_cnt++;
         p_dma_start = gf;
         if (gf) p_dma_sel = iss[0];
         p_b2s_start = gd;
         if (gd) p_b2s_sel = dis[0];
         if ((dma_done && !fo) || (b2s_done && !dout)) m_err = 1;
         drn0 = drn;
         iss += int'(gf);
         fdn += int'(dma_done && fo);
         dis += int'(gd);
         drn += int'(b2s_done && dout);
         if (m_phase == 0 && sched_start) begin
            m_fst = 0; m_dst = 0;
         end else begin
            if (sf && m_fst < 65535) m_fst++;
            if (sd && m_dst < 65535) m_dst++;
         end
         if (m_phase == 0) begin
            if (sched_start) begin
               m_num = int'(num_tiles); m_tw = int'(tile_words);
               iss = 0; fdn = 0; dis = 0; drn = 0;
               m_phase = (num_tiles == 0) ? 2 : 1;
            end
         end else if (m_phase == 1) begin
            if (drn0 == m_num) m_phase = 2;
         end else m_phase = 0;
      end
   end

   // per-cycle comparison, start recording and engine emulation (done pulses after a fixed or random delay)
   int   n_dma = 0, n_b2s = 0, dc = 0, bc = 0, d_dly = 6, b_dly = 10;
   bit   rnd = 0;
   logic sel_d [4096];
   always @(negedge clk) begin
      if (rst) begin
         erw = 2'b11;
         if (dis > drn) erw = ((dis - 1) % 2 == 1) ? 2'b01 : 2'b10;
         chk("dma_start", 32'(dma_start), 32'(p_dma_start));
         chk("dma_buf_select", 32'(dma_buf_select), 32'(p_dma_sel));
         chk("b2s_start", 32'(b2s_start), 32'(p_b2s_start));
         chk("b2s_buf_select", 32'(b2s_buf_select), 32'(p_b2s_sel));
         chk("rw_select", 32'(input_buffer_rw_select), 32'(erw));
         chk("sched_busy", 32'(sched_busy), 32'(m_phase == 1));
         chk("sched_done", 32'(sched_done), 32'(m_phase == 2));
         chk("sched_err", 32'(sched_err), 32'(m_err));
         chk("addr_end", 32'(b2s_buf_addr_end), 32'(m_tw));
`ifdef SCHED_PERF_EN
         chk("fill_stall_cnt", 32'(fill_stall_cnt), 32'(m_fst));
         chk("drain_stall_cnt", 32'(drain_stall_cnt), 32'(m_dst));
`endif
         if (dma_start) begin sel_d[n_dma % 4096] = dma_buf_select; n_dma++; end
         n_b2s += int'(b2s_start);
      end
      r_dma = 1'b0;
      if (dc > 0) begin dc--; if (dc == 0) r_dma = 1'b1; end
      if (dma_start) dc = rnd ? int'($urandom_range(1, 8)) : d_dly;
      r_b2s = 1'b0;
      if (bc > 0) begin bc--; if (bc == 0) r_b2s = 1'b1; end
      if (b2s_start) bc = rnd ? int'($urandom_range(1, 8)) : b_dly;
   end

   task automatic check_reset(input string tag);
      chk({tag, "_dma_start"}, 32'(dma_start), 0);
      chk({tag, "_b2s_start"}, 32'(b2s_start), 0);
      chk({tag, "_sels"}, 32'({dma_buf_select, b2s_buf_select}), 0);
      chk({tag, "_addr_end"}, 32'(b2s_buf_addr_end), 0);
      chk({tag, "_rw"}, 32'(input_buffer_rw_select), 32'd3);
      chk({tag, "_busy_done_err"}, 32'({sched_busy, sched_done, sched_err}), 0);
   endtask
   task automatic do_reset();
      @(negedge clk); #2 rst = 1'b0;
      #1 check_reset("async_rst");
      @(negedge clk); #2 rst = 1'b1;
   endtask
   task automatic start(input int n, input int w);
      @(negedge clk); sched_start = 1'b1; num_tiles = 16'(n); tile_words = 7'(w);
      @(negedge clk); sched_start = 1'b0;
   endtask
   task automatic wait_done(input int lim, input string tag);
      int i = 0;
      while (!sched_done && i < lim) begin @(negedge clk); i++; end
      chk(tag, 32'(sched_done), 32'd1);
   endtask

   int m0, b0;
   initial begin
      sched_start = 0; num_tiles = 0; tile_words = 0; drain_ready = 0;
      repeat (2) @(negedge clk);
      check_reset("init");
      #2 rst = 1'b1;
      // spurious fill completion while idle
      @(negedge clk); f_dma = 1'b1;
      @(negedge clk); f_dma = 1'b0;
      @(negedge clk);
      chk("spur_err", 32'(sched_err), 1);
      chk("spur_busy", 32'(sched_busy), 0);
      chk("spur_rw", 32'(input_buffer_rw_select), 32'd3);
      do_reset();
      // three tiles, fill 6 cycles, drain 10 cycles
      drain_ready = 1'b1; d_dly = 6; b_dly = 10;
      m0 = n_dma; b0 = n_b2s;
      start(3, 99);
      wait_done(300, "run3_done");
      chk("run3_dma_cnt", 32'(n_dma - m0), 32'd3);
      chk("run3_b2s_cnt", 32'(n_b2s - b0), 32'd3);
      for (int i = 0; i < 3; i++) chk("run3_dma_seq", 32'(sel_d[(m0 + i) % 4096]), 32'(i % 2));
      chk("run3_addr_end", 32'(b2s_buf_addr_end), 32'd99);
      // zero tiles: done without any engine activity
      m0 = n_dma; b0 = n_b2s;
      start(0, 5);
      wait_done(1, "zero_done");
      @(negedge clk);
      chk("zero_starts", 32'(n_dma - m0 + n_b2s - b0), 0);
      // drain blocked: both buffers fill, then release
      drain_ready = 1'b0; d_dly = 3; b_dly = 4;
      m0 = n_dma; b0 = n_b2s;
      start(4, 17);
      repeat (10) @(negedge clk);
      sched_start = 1'b1; num_tiles = 0;
      @(negedge clk); sched_start = 1'b0;
      repeat (12) @(negedge clk);
      chk("blk_dma_cnt", 32'(n_dma - m0), 32'd2);
      chk("blk_b2s_cnt", 32'(n_b2s - b0), 0);
      chk("blk_rw", 32'(input_buffer_rw_select), 32'd3);
      chk("blk_busy", 32'(sched_busy), 1);
      drain_ready = 1'b1;
      for (int i = 0; i < 2 && !b2s_start; i++) @(negedge clk);
      chk("blk_release_b2s", 32'({b2s_start, b2s_buf_select}), 32'b10);
      wait_done(200, "blk_done");
      chk("blk_total_dma", 32'(n_dma - m0), 32'd4);
      // equal delays make a fill and a drain complete together
      d_dly = 6; b_dly = 6; b0 = both_cnt;
      start(4, 33);
      wait_done(300, "sim_done");
      chk("sim_seen", 32'(both_cnt - b0 > 0), 1);
      // reset during a drain, then stale completions
      d_dly = 2; b_dly = 8; b0 = n_b2s;
      start(2, 10);
      for (int i = 0; i < 40 && n_b2s == b0; i++) @(negedge clk);
      chk("mid_b2s_seen", 32'(n_b2s - b0), 1);
      do_reset();
      repeat (14) @(negedge clk);
      chk("stale_err", 32'(sched_err), 1);
      m0 = n_dma;
      start(2, 10);
      wait_done(200, "after_rst_done");
      chk("after_rst_dma", 32'(n_dma - m0), 32'd2);
      // randomized runs: random tile counts, engine delays and drain backpressure
      rnd = 1;
      for (int r = 0; r < 8; r++) begin
         int k;
         k = 0;
         start(int'($urandom_range(1, 6)), int'($urandom_range(0, 127)));
         while (!sched_done && k < 600) begin
            drain_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            k++;
         end
         chk("rand_done", 32'(sched_done), 1);
         drain_ready = 1'b1;
      end
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
